// File: rtl/accelerator_pkg.sv
// Shared types and defaults for the scalar-core to vector-accelerator APU interface.
package accelerator_pkg;

  typedef struct packed {
    logic [5:0]       op;
    logic [14:0]      flags;
    logic [2:0][31:0] operands;
  } apu_req_t;

  localparam int APU_REQ_W                     = $bits(apu_req_t);
  localparam int APU_Q_DEPTH_DEFAULT           = 4;
  localparam int APU_Q_MAX_OUTSTANDING_DEFAULT = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an exact occupancy count; DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == (AW+1)'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign data_o  = r_mem[r_rptr];

  // Overflow/underflow requests are dropped here so callers need not guard them.
  assign w_push = push_i & ~full_o;
  assign w_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

endmodule

// File: rtl/apu_issue_queue.sv
// Request queue between the core APU port and the accelerator, with in-flight limit and registered results.
// Optional zero-latency empty-queue bypass when APU_ISSUE_QUEUE_BYPASS_EN is defined.
module apu_issue_queue
  import accelerator_pkg::*;
#(
  parameter int DEPTH           = APU_Q_DEPTH_DEFAULT,
  parameter int MAX_OUTSTANDING = APU_Q_MAX_OUTSTANDING_DEFAULT
) (
  input  logic                             clk,
  input  logic                             n_reset,
  input  logic                             core_req_i,
  output logic                             core_gnt_o,
  input  logic [2:0][31:0]                 core_operands_i,
  input  logic [5:0]                       core_op_i,
  input  logic [14:0]                      core_flags_i,
  output logic                             core_rvalid_o,
  output logic [31:0]                      core_result_o,
  output logic [4:0]                       core_rflags_o,
  output logic                             acc_req_o,
  input  logic                             acc_gnt_i,
  output logic [2:0][31:0]                 acc_operands_o,
  output logic [5:0]                       acc_op_o,
  output logic [14:0]                      acc_flags_o,
  input  logic                             acc_rvalid_i,
  input  logic [31:0]                      acc_result_i,
  input  logic [4:0]                       acc_rflags_i,
  output logic [$clog2(DEPTH):0]           count_o,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o,
  output logic                             err_o
);

  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

  logic                 w_full;
  logic                 w_empty;
  logic [APU_REQ_W-1:0] w_head_bits;
  apu_req_t             w_head;
  apu_req_t             w_core_req;
  apu_req_t             w_acc_req;
  logic                 w_room;
  logic                 w_bypass;
  logic                 w_issue;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_ret;

  logic [OW-1:0]        r_outstanding;
  logic                 r_err;
  logic                 r_vld_p1;
  logic [31:0]          r_result_p1;
  logic [4:0]           r_rflags_p1;

  assign w_core_req.op       = core_op_i;
  assign w_core_req.flags    = core_flags_i;
  assign w_core_req.operands = core_operands_i;
  assign w_head              = apu_req_t'(w_head_bits);

  assign w_room = (r_outstanding != OW'(MAX_OUTSTANDING));

`ifdef APU_ISSUE_QUEUE_BYPASS_EN
  assign w_bypass = w_empty & core_req_i & w_room;
`else
  assign w_bypass = 1'b0;
`endif

  assign core_gnt_o = ~w_full;
  assign acc_req_o  = (~w_empty & w_room) | w_bypass;
  assign w_acc_req  = w_bypass ? w_core_req : w_head;
  assign acc_op_o       = w_acc_req.op;
  assign acc_flags_o    = w_acc_req.flags;
  assign acc_operands_o = w_acc_req.operands;

  // A bypassed request that is granted immediately never touches the FIFO.
  assign w_issue = acc_req_o & acc_gnt_i;
  assign w_push  = core_req_i & core_gnt_o & ~(w_bypass & acc_gnt_i);
  assign w_pop   = w_issue & ~w_bypass;
  assign w_ret   = acc_rvalid_i & (r_outstanding != '0);

  sync_fifo #(
    .WIDTH (APU_REQ_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (w_core_req),
    .data_o  (w_head_bits),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (count_o)
  );

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_outstanding <= '0;
      r_err         <= 1'b0;
    end else begin
      case ({w_issue, w_ret})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
      if (acc_rvalid_i && (r_outstanding == '0)) r_err <= 1'b1;
    end
  end

  // p1: registered result return; payload holds when no result is returned.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_vld_p1    <= 1'b0;
      r_result_p1 <= '0;
      r_rflags_p1 <= '0;
    end else begin
      r_vld_p1 <= w_ret;
      if (w_ret) begin
        r_result_p1 <= acc_result_i;
        r_rflags_p1 <= acc_rflags_i;
      end
    end
  end

  assign outstanding_o = r_outstanding;
  assign err_o         = r_err;
  assign core_rvalid_o = r_vld_p1;
  assign core_result_o = r_result_p1;
  assign core_rflags_o = r_rflags_p1;

endmodule
